// File: rtl/key_flap_conditioner.sv
// key_flap_conditioner
// Cleans up the raw flap pushbutton for the CPU key port: two-flop
// synchroniser, counter debounce, one-cycle press pulse, and a saturating
// pending-press counter that software drains with an acknowledge strobe.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | key accepted as released, oLEVEL = 0
// PRESS_WAIT   | key seen pressed, counting stable cycles before accepting
// HELD         | key accepted as pressed, oLEVEL = 1
// RELEASE_WAIT | key seen released, counting stable cycles before accepting

module key_flap_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int PEND_W          = 3,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iKEY,
    input  logic              iACK,
    output logic              oLEVEL,
    output logic              oPRESS,
    output logic              oFLAP,
    output logic [PEND_W-1:0] oPENDING,
    output logic              oOVF
);

    // Raw pin level that means "not pressed"; the synchroniser resets to it
    // so a key held through reset has to be debounced from scratch.
    localparam logic              KEY_RELEASED = KEY_ACTIVE_LOW;
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX     = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic              key_meta;
    logic              key_sync;
    logic              key_pressed;
    state_t            state;
    logic [CNT_W-1:0]  db_cnt;
    logic [PEND_W-1:0] pend_next;
    logic              ovf_set;

    // Two-flop synchroniser on the asynchronous pin.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            key_meta <= KEY_RELEASED;
            key_sync <= KEY_RELEASED;
        end else begin
            key_meta <= iKEY;
            key_sync <= key_meta;
        end
    end

    // Normalise polarity: key_pressed = 1 always means the button is down.
    assign key_pressed = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

    // Debounce FSM; the counter restarts on every state change so a
    // glitch of any length below the debounce window leaves no trace.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            db_cnt <= '0;
            oLEVEL <= 1'b0;
            oPRESS <= 1'b0;
        end else begin
            oPRESS <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_pressed) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_pressed) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == CNT_LAST) begin
                        state  <= HELD;
                        db_cnt <= '0;
                        oLEVEL <= 1'b1;
                        oPRESS <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!key_pressed) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_pressed) begin
                        // Bounce back to pressed: same press, no new pulse.
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == CNT_LAST) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                        oLEVEL <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                    oLEVEL <= 1'b0;
                end
            endcase
        end
    end

    // Next pending count; a press and an ack in the same cycle cancel out,
    // so overflow is only flagged for a press nobody consumed.
    always_comb begin
        pend_next = oPENDING;
        ovf_set   = 1'b0;
        if (oPRESS && !iACK) begin
            if (oPENDING == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_next = oPENDING + 1'b1;
            end
        end else if (!oPRESS && iACK && (oPENDING != '0)) begin
            pend_next = oPENDING - 1'b1;
        end
    end

    // Pending counter with flag and sticky overflow, registered together.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oPENDING <= '0;
            oFLAP    <= 1'b0;
            oOVF     <= 1'b0;
        end else begin
            oPENDING <= pend_next;
            oFLAP    <= (pend_next != '0);
            if (ovf_set) begin
                oOVF <= 1'b1;
            end
        end
    end

endmodule

// File: doc/key_flap_conditioner.md
Name: key_flap_conditioner

Overview:
Conditions the raw flap pushbutton before it reaches the CPU key input port. Performs:
- two-flop synchronisation of the bouncy asynchronous pushbutton;
- counter-based debounce;
- one-cycle press-event generation;
- a saturating pending-press counter that software drains through an acknowledge strobe.

Presses are therefore never lost between CPU polls. It sits between the board KEY pin and the kernel's key PIO, and is reset by the delayed system reset.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a new raw level must stay stable before acceptance (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, debounce counter width.
- PEND_W, 3, pending-press counter width; saturates at 2^PEND_W-1.
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed.

Ports:
- iCLK  input  1  system clock, 50 MHz.
- iRST  input  1  asynchronous active-low reset.
- iKEY  input  1  raw pushbutton, asynchronous to iCLK.
- iACK  input  1  synchronous consume strobe from CPU; each high cycle removes one pending press.
- oLEVEL  output  1  debounced key state, 1 = pressed.
- oPRESS  output  1  one-cycle pulse on accepted press.
- oFLAP  output  1  high while oPENDING != 0.
- oPENDING  output  PEND_W  number of unconsumed presses.
- oOVF  output  1  sticky: a press arrived while oPENDING was saturated.

Behaviour:

Reset (iRST low, asynchronous):
- Synchroniser flops load the released level (1 if KEY_ACTIVE_LOW, else 0).
- Debounce counter = 0; state = IDLE.
- oLEVEL = 0, oPRESS = 0, oFLAP = 0, oPENDING = 0, oOVF = 0.
- Deassertion takes effect on the next iCLK edge.
- Reset mid-debounce discards the partial count. Reset mid-press: a key still held after reset must go through the full debounce before it is accepted.

Synchroniser:
- Two flops on iKEY, then polarity normalised so that k_s = 1 means pressed.
- Nothing downstream samples iKEY directly.

State machine (all transitions on iCLK rising edge):
- IDLE (oLEVEL = 0):
  - k_s = 1 → PRESS_WAIT, counter cleared to 0.
- PRESS_WAIT:
  - k_s = 0 → IDLE, counter cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with k_s still 1 → HELD. oLEVEL rises and oPRESS pulses on that same edge.
- HELD (oLEVEL = 1):
  - k_s = 0 → RELEASE_WAIT, counter cleared.
- RELEASE_WAIT:
  - k_s = 1 → HELD, counter cleared, no new oPRESS.
  - Otherwise the counter increments.
  - At DEBOUNCE_CYCLES-1 → IDLE and oLEVEL falls.

Latency: press to oPRESS is 2 sync cycles plus DEBOUNCE_CYCLES cycles. Any glitch shorter than DEBOUNCE_CYCLES produces no output change.

Pending counter (registered, updated every cycle):
- Press only: increment, unless saturated; if saturated, hold and set oOVF.
- iACK only: decrement if nonzero; iACK at 0 is ignored (no underflow).
- Press and iACK in the same cycle: counter unchanged; oOVF is not set even when saturated.
- oFLAP is registered and valid in the same cycle as oPENDING.
- oOVF clears only on reset.

Arithmetic: all counters are unsigned. The debounce counter never exceeds DEBOUNCE_CYCLES-1 and does not wrap.

Test Plan (DEBOUNCE_CYCLES = 8 for simulation):
- Reset: hold iRST low with iKEY = 0 (pressed) → all outputs 0. Release reset and keep the key pressed → oPRESS pulses exactly once, 10 cycles after the first clean edge; oLEVEL = 1; oPENDING = 1; oFLAP = 1.
- Bounce: iKEY toggles every 3 cycles for 40 cycles, then stays low → single oPRESS 10 cycles after the last toggle; oPENDING = 1.
- Short release: with the key held (HELD), pulse iKEY high for 5 cycles → oLEVEL stays 1, no oPRESS, oPENDING unchanged.
- Saturation: 9 clean presses with no iACK → oPENDING = 7, oOVF = 1 after the 8th. Then 7 iACK pulses → oPENDING = 0, oFLAP = 0, oOVF still 1. An extra iACK leaves oPENDING = 0.
- Simultaneous events: oPENDING = 2 with iACK high in the oPRESS cycle → oPENDING stays 2. Repeat at oPENDING = 7 → stays 7, oOVF remains 0 (starting from a fresh reset).
- Reset mid-debounce: assert iRST 4 cycles into PRESS_WAIT → no oPRESS. After release with the key still held, a full 10-cycle latency applies before oPRESS.
